bht_update_ctrl: RTL and testbench
==================================

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 SHALL have parameter M, default 16: number of BHT entries, power of two, 2..512.
REQ-002 SHALL have parameter DEPTH, default 4: resolve-queue depth, power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: restarts table initialisation and discards the queue.
REQ-006 SHALL have port resolve_valid, input, 1: a resolved-branch outcome is offered.
REQ-007 SHALL have port resolve_pc, input, 9: PC of the resolved branch.
REQ-008 SHALL have port resolve_taken, input, 1: outcome of the resolved branch.
REQ-009 SHALL have port resolve_ready, output, 1: the queue accepts an outcome this cycle.
REQ-010 SHALL have port lookup_valid, input, 1: the fetch stage requests a BHT prediction read.
REQ-011 SHALL have port lookup_grant, output, 1: combinational; the lookup uses the BHT this cycle.
REQ-012 SHALL have port lookup_stall, output, 1: combinational; lookup_valid high and not granted.
REQ-013 SHALL have port upd_en, output, 1: registered; BHT write strobe.
REQ-014 SHALL have port upd_pc, output, 9: registered; BHT write index source.
REQ-015 SHALL have port upd_taken, output, 1: registered; BHT write outcome.
REQ-016 SHALL have port busy, output, 1: high while in state INIT.

Function
REQ-017 SHALL implement a two-state FSM, INIT and RUN.
REQ-018 In INIT, SHALL issue one write per cycle using an index counter idx running 0..M-1: upd_en=1, upd_pc=idx zero-extended, upd_taken=0.
REQ-019 SHALL move from INIT to RUN on the edge that issues idx=M-1.
REQ-020 In INIT, SHALL drive resolve_ready=0 and lookup_grant=0.
REQ-021 flush in RUN SHALL enter INIT with idx=0 and queue count=0 on the next edge.
REQ-022 flush in INIT SHALL restart idx at 0.
REQ-023 flush SHALL take priority over push and pop in the same cycle.
REQ-024 The queue SHALL be a circular FIFO of DEPTH entries {pc, taken}, with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
REQ-025 resolve_ready SHALL equal (state==RUN) && (count<DEPTH).
REQ-026 A push SHALL occur when resolve_valid && resolve_ready.
REQ-027 In RUN, a pop SHALL occur when count>0 && (!lookup_valid || count==DEPTH).
- Lookups have priority over updates.
- A full queue forces a drain.
REQ-028 lookup_grant SHALL equal lookup_valid && state==RUN && count<DEPTH.
REQ-029 A pop SHALL register the FIFO head onto upd_pc/upd_taken with upd_en=1 on the next edge (latency 1 cycle).
REQ-030 Otherwise, in RUN, upd_en SHALL be registered 0, and upd_pc/upd_taken SHALL hold their values.
REQ-031 A simultaneous push and pop SHALL leave count unchanged; an entry pushed into an empty queue SHALL NOT be popped in the same cycle.
REQ-032 Queue order SHALL be strictly FIFO.

Reset
REQ-033 reset SHALL immediately force the following: state=INIT, idx=0, pointers=0, count=0, upd_en=0, upd_pc=0, upd_taken=0.
REQ-034 The first INIT write SHALL appear on the first rising clk edge after reset deasserts.
REQ-035 reset asserted mid-INIT or mid-RUN SHALL discard all queue contents and progress.

Configuration
REQ-036 With macro BHT_CTRL_STATS_EN defined, SHALL add output stall_cnt, 16 bits: saturating count of cycles with lookup_stall=1, cleared by reset only, held at 16'hFFFF on overflow.
REQ-037 Without BHT_CTRL_STATS_EN, the stall_cnt port and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-038 Reset, then run 16 cycles (M=16) -> upd_en=1 with upd_pc=0..15 consecutively, upd_taken=0, busy=1; busy=0 at cycle 17.
REQ-039 In RUN with lookup_valid=0, push pc=0x1A0/taken=1 -> next cycle upd_en=1, upd_pc=0x1A0, upd_taken=1; next cycle upd_en=0.
REQ-040 Hold lookup_valid=1 and push 4 outcomes (DEPTH=4) -> resolve_ready=0 when count=4; lookup_stall=1 that cycle; the oldest entry is drained; the fifth push is accepted the following cycle.
REQ-041 Assert flush with 3 queued entries -> busy=1, resolve_ready=0, queue empty, 16 init writes, none of the 3 entries is ever written.
REQ-042 Assert reset mid-INIT at idx=7 -> upd_en=0 asynchronously; after release, init restarts at upd_pc=0.
REQ-043 With BHT_CTRL_STATS_EN, hold a stall for 70000 cycles -> stall_cnt=16'hFFFF; without the macro, the design elaborates with no stall_cnt port.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// rtl/bht_update_ctrl.sv - BHT initialisation sweep plus resolved-branch update queue.
// Optional stall statistics counter enabled by defining BHT_CTRL_STATS_EN.
module bht_update_ctrl #(
  parameter int M     = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       resolve_valid,
  input  logic [8:0] resolve_pc,
  input  logic       resolve_taken,
  output logic       resolve_ready,
  input  logic       lookup_valid,
  output logic       lookup_grant,
  output logic       lookup_stall,
  output logic       upd_en,
  output logic [8:0] upd_pc,
  output logic       upd_taken,
  output logic       busy
`ifdef BHT_CTRL_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [8:0] pc_mem    [DEPTH];
  logic       taken_mem [DEPTH];

  logic not_full;
  logic push;
  logic pop;

  assign not_full      = (count < CW'(DEPTH));
  assign busy          = (state == INIT);
  assign resolve_ready = (state == RUN) && not_full;
  assign lookup_grant  = lookup_valid && (state == RUN) && not_full;
  assign lookup_stall  = lookup_valid && !lookup_grant;
  assign push          = resolve_valid && resolve_ready && !flush;
  // Lookups win the table port unless the queue is full, which forces a drain.
  assign pop           = (state == RUN) && !flush && (count != '0) &&
                         (!lookup_valid || !not_full);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resolve_pc;
      taken_mem[wr_ptr] <= resolve_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      idx       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      upd_en    <= 1'b0;
      upd_pc    <= '0;
      upd_taken <= 1'b0;
    end else if (flush) begin
      state  <= INIT;
      idx    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      upd_en <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          upd_en    <= 1'b1;
          upd_pc    <= 9'(idx);
          upd_taken <= 1'b0;
          if (idx == IW'(M - 1)) begin
            state <= RUN;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        RUN: begin
          upd_en <= pop;
          if (pop) begin
            upd_pc    <= pc_mem[rd_ptr];
            upd_taken <= taken_mem[rd_ptr];
            rd_ptr    <= rd_ptr + PW'(1);
          end
          if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
          end
          count <= count + CW'(push) - CW'(pop);
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef BHT_CTRL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (lookup_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb/tb_bht_update_ctrl.sv - Self-checking bench for bht_update_ctrl (M=16, DEPTH=4).
module tb_bht_update_ctrl;
  localparam int M     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       resolve_valid = 1'b0;
  logic [8:0] resolve_pc = '0;
  logic       resolve_taken = 1'b0;
  logic       resolve_ready;
  logic       lookup_valid = 1'b0;
  logic       lookup_grant;
  logic       lookup_stall;
  logic       upd_en;
  logic [8:0] upd_pc;
  logic       upd_taken;
  logic       busy;
`ifdef BHT_CTRL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  bht_update_ctrl #(.M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
    .lookup_valid(lookup_valid), .lookup_grant(lookup_grant),
    .lookup_stall(lookup_stall), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .busy(busy)
`ifdef BHT_CTRL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: "still initialising" flag, sweep position, and a plain queue.
  bit         m_init;
  int         m_idx;
  logic [9:0] m_q[$];
  logic       m_upd_en;
  logic [8:0] m_upd_pc;
  logic       m_upd_taken;

  logic a_ready, a_grant, a_stall, a_busy;

  typedef struct {
    logic fl, rv; logic [8:0] pc; logic tk, lv;
    logic ready, grant, stall, en; logic [8:0] upc; logic utk;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_idx = 0; m_q.delete();
    m_upd_en = 0; m_upd_pc = '0; m_upd_taken = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic cycle(input logic fl, input logic rv, input logic [8:0] pc,
                       input logic tk, input logic lv);
    bit e_ready, e_grant, e_stall, do_pop;
    logic [9:0] e;
    int sz;
    flush = fl; resolve_valid = rv; resolve_pc = pc; resolve_taken = tk; lookup_valid = lv;
    #3;
    sz = m_q.size();
    e_ready = !m_init && (sz < DEPTH);
    e_grant = lv && e_ready;
    e_stall = lv && !e_grant;
    a_ready = resolve_ready; a_grant = lookup_grant; a_stall = lookup_stall; a_busy = busy;
    chk("resolve_ready", a_ready, e_ready);
    chk("lookup_grant", a_grant, e_grant);
    chk("lookup_stall", a_stall, e_stall);
    chk("busy", a_busy, m_init);
    if (fl) begin
      m_init = 1; m_idx = 0; m_q.delete(); m_upd_en = 0;
    end else if (m_init) begin
      m_upd_en = 1; m_upd_pc = 9'(m_idx); m_upd_taken = 0;
      if (m_idx == M - 1) begin m_init = 0; m_idx = 0; end
      else m_idx++;
    end else begin
      do_pop = (sz > 0) && (!lv || sz == DEPTH);
      m_upd_en = do_pop;
      if (do_pop) begin
        e = m_q.pop_front();
        m_upd_pc = e[9:1]; m_upd_taken = e[0];
      end
      if (rv && e_ready) m_q.push_back({pc, tk});
    end
    @(posedge clk); #1;
    chk("upd_en", upd_en, m_upd_en);
    chk("upd_pc", upd_pc, m_upd_pc);
    chk("upd_taken", upd_taken, m_upd_taken);
  endtask

  task automatic idle(input int n, input logic lv);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, lv);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 9'h1A0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h00F, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h1A0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h1A0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 9'h055, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1A0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 9'h0AA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1A0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h055, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h0AA, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 9'h123, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0AA, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_upd_en", upd_en, 1'b0);
    chk("reset_upd_pc", upd_pc, 9'h000);
    chk("reset_busy", busy, 1'b1);
    chk("reset_ready", resolve_ready, 1'b0);
    reset = 1'b0;

    // Initialisation sweep
    for (int k = 0; k < M; k++) begin
      cycle(0, 0, '0, 0, 0);
      chk("init_upd_en", upd_en, 1'b1);
      chk("init_upd_pc", upd_pc, 9'(k));
      chk("init_busy_after", busy, (k == M - 1) ? 1'b0 : 1'b1);
    end
    idle(1, 0);
    chk("run_idle_upd_en", upd_en, 1'b0);

    // Table-driven vectors from a known RUN state with empty queue
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].fl, tbl[i].rv, tbl[i].pc, tbl[i].tk, tbl[i].lv);
      chk($sformatf("tbl%0d_ready", i), a_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_grant", i), a_grant, tbl[i].grant);
      chk($sformatf("tbl%0d_stall", i), a_stall, tbl[i].stall);
      chk($sformatf("tbl%0d_upd_en", i), upd_en, tbl[i].en);
      chk($sformatf("tbl%0d_upd_pc", i), upd_pc, tbl[i].upc);
      chk($sformatf("tbl%0d_upd_taken", i), upd_taken, tbl[i].utk);
    end
    idle(M - 1, 1);
    idle(2, 0);

    // Full queue under continuous lookups forces a drain of the oldest entry
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1, 9'h100 + 9'(i), i[0], 1);
      chk("fill_grant", a_grant, 1'b1);
      chk("fill_no_upd", upd_en, 1'b0);
    end
    cycle(0, 1, 9'h1EE, 1, 1);
    chk("full_ready", a_ready, 1'b0);
    chk("full_stall", a_stall, 1'b1);
    chk("drain_upd_en", upd_en, 1'b1);
    chk("drain_upd_pc", upd_pc, 9'h100);
    cycle(0, 1, 9'h1EE, 1, 1);
    chk("fifth_push_ready", a_ready, 1'b1);
    idle(8, 0);

    // Flush with three queued entries: none of them may ever be written
    for (int i = 0; i < 3; i++) cycle(0, 1, 9'h1C0 + 9'(i), 1, 1);
    cycle(1, 0, '0, 0, 1);
    chk("flush_busy", busy, 1'b1);
    chk("flush_ready", resolve_ready, 1'b0);
    for (int k = 0; k < M; k++) begin
      cycle(0, 0, '0, 0, 0);
      chk("flush_init_pc", upd_pc, 9'(k));
      chk("flush_init_taken", upd_taken, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, '0, 0, 0);
      chk("flush_discarded", upd_en, 1'b0);
    end

    // Asynchronous reset in the middle of initialisation
    cycle(1, 0, '0, 0, 0);
    idle(7, 0);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_upd_en", upd_en, 1'b0);
    chk("async_rst_upd_pc", upd_pc, 9'h000);
    model_reset();
    @(posedge clk); #1;
    chk("rst_held_upd_en", upd_en, 1'b0);
    reset = 1'b0;
    cycle(0, 0, '0, 0, 0);
    chk("restart_pc", upd_pc, 9'h000);
    chk("restart_en", upd_en, 1'b1);
    idle(M - 1, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 79) == 0), $urandom_range(0, 9) < 7, 9'($urandom),
            1'($urandom), $urandom_range(0, 9) < 6);
    end

`ifdef BHT_CTRL_STATS_EN
    flush = 1'b1; lookup_valid = 1'b1; resolve_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
